// File: rtl/lsu_bus_master.sv
// ---------------------------------------------------------------------------
// lsu_bus_master
//   Load/store unit bus master. Accepts one memory operation at a time from
//   decode, computes the effective address, checks alignment, runs a single
//   request/acknowledge transfer on the memory bus with a timeout, and writes
//   extracted load data back to the register file.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   issue_valid / issue_ready    decode handshake (ready only when idle)
//   flush                        blocks acceptance of the offered operation
//   operation_con, src1_value,
//   src2_value, imm, rd          operation code, base, store data, offset, dest
//   mem_req/we/addr/be/wdata     bus request (word address, byte enables)
//   mem_ack, mem_rdata           bus completion and read data
//   write_req/addr/data          register writeback
//   exc_misaligned, exc_timeout  one-cycle exception pulses
// ---------------------------------------------------------------------------
module lsu_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [5:0]  OP_LB  = 6'd11,
    parameter logic [5:0]  OP_LH  = 6'd12,
    parameter logic [5:0]  OP_LW  = 6'd13,
    parameter logic [5:0]  OP_LBU = 6'd14,
    parameter logic [5:0]  OP_LHU = 6'd15,
    parameter logic [5:0]  OP_SB  = 6'd16,
    parameter logic [5:0]  OP_SH  = 6'd17,
    parameter logic [5:0]  OP_SW  = 6'd18
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        issue_valid,
    output logic        issue_ready,
    input  logic        flush,
    input  logic [5:0]  operation_con,
    input  logic [31:0] src1_value,
    input  logic [31:0] src2_value,
    input  logic [31:0] imm,
    input  logic [4:0]  rd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [29:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        write_req,
    output logic [4:0]  write_addr,
    output logic [31:0] write_data,
    output logic        exc_misaligned,
    output logic        exc_timeout
);

    typedef enum logic [1:0] {IDLE, REQ, WB} state_t;

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [5:0]    op_q, op_d;
    logic [4:0]    rd_q, rd_d;
    logic [1:0]    ea_lo_q, ea_lo_d;
    logic          issue_ready_q, issue_ready_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [29:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_be_q, mem_be_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;
    logic          write_req_q, write_req_d;
    logic [4:0]    write_addr_q, write_addr_d;
    logic [31:0]   write_data_q, write_data_d;
    logic          exc_mis_q, exc_mis_d;
    logic          exc_to_q, exc_to_d;

    logic [31:0] ea;
    logic        op_byte, op_half, op_word, op_store, op_known, misaligned, accept;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;
    logic        pend_load;

    // Decode of the offered operation (current inputs).
    always_comb begin
        ea        = src1_value + imm;
        op_byte   = (operation_con == OP_LB) || (operation_con == OP_LBU) || (operation_con == OP_SB);
        op_half   = (operation_con == OP_LH) || (operation_con == OP_LHU) || (operation_con == OP_SH);
        op_word   = (operation_con == OP_LW) || (operation_con == OP_SW);
        op_store  = (operation_con == OP_SB) || (operation_con == OP_SH) || (operation_con == OP_SW);
        op_known  = op_byte || op_half || op_word;
        misaligned = (op_half && ea[0]) || (op_word && (ea[1:0] != 2'b00));
        accept    = issue_valid && issue_ready_q && !flush && op_known;

        // Loads always enable the whole word; lanes are picked on return.
        be_new    = 4'b1111;
        wdata_new = src2_value;
        if (op_store && op_byte) begin
            be_new    = 4'b0001 << ea[1:0];
            wdata_new = {4{src2_value[7:0]}};
        end else if (op_store && op_half) begin
            be_new    = ea[1] ? 4'b1100 : 4'b0011;
            wdata_new = {2{src2_value[15:0]}};
        end
    end

    // Extraction of the returning load word using the latched address lanes.
    always_comb begin
        case (ea_lo_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = ea_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (op_q == OP_LB)       ld_value = {{24{ld_byte[7]}}, ld_byte};
        else if (op_q == OP_LBU) ld_value = {24'd0, ld_byte};
        else if (op_q == OP_LH)  ld_value = {{16{ld_half[15]}}, ld_half};
        else if (op_q == OP_LHU) ld_value = {16'd0, ld_half};
        else                     ld_value = mem_rdata;
        pend_load = (op_q == OP_LB) || (op_q == OP_LBU) || (op_q == OP_LH) ||
                    (op_q == OP_LHU) || (op_q == OP_LW);
    end

    // Next-state logic.
    always_comb begin
        // NOTE: every target gets a hold/default value first so no path through the case infers a latch.
        state_d      = state_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        rd_d         = rd_q;
        ea_lo_d      = ea_lo_q;
        mem_req_d    = mem_req_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_be_d     = mem_be_q;
        mem_wdata_d  = mem_wdata_q;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        write_req_d  = 1'b0;
        exc_mis_d    = 1'b0;
        exc_to_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (misaligned) begin
                        exc_mis_d = 1'b1;
                    end else begin
                        state_d     = REQ;
                        cnt_d       = '0;
                        op_d        = operation_con;
                        rd_d        = rd;
                        ea_lo_d     = ea[1:0];
                        mem_req_d   = 1'b1;
                        mem_we_d    = op_store;
                        mem_addr_d  = ea[31:2];
                        mem_be_d    = be_new;
                        mem_wdata_d = wdata_new;
                    end
                end
            end
            REQ: begin
                // An ack in the final counted cycle takes priority over the timeout.
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    if (pend_load) begin
                        state_d = WB;
                        if (rd_q != 5'd0) begin
                            write_req_d  = 1'b1;
                            write_addr_d = rd_q;
                            write_data_d = ld_value;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    mem_req_d = 1'b0;
                    exc_to_d  = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase

        issue_ready_d = (state_d == IDLE);
    end

    // NOTE: all state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            op_q          <= '0;
            rd_q          <= '0;
            ea_lo_q       <= '0;
            issue_ready_q <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_be_q      <= '0;
            mem_wdata_q   <= '0;
            write_req_q   <= 1'b0;
            write_addr_q  <= '0;
            write_data_q  <= '0;
            exc_mis_q     <= 1'b0;
            exc_to_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            op_q          <= op_d;
            rd_q          <= rd_d;
            ea_lo_q       <= ea_lo_d;
            issue_ready_q <= issue_ready_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_be_q      <= mem_be_d;
            mem_wdata_q   <= mem_wdata_d;
            write_req_q   <= write_req_d;
            write_addr_q  <= write_addr_d;
            write_data_q  <= write_data_d;
            exc_mis_q     <= exc_mis_d;
            exc_to_q      <= exc_to_d;
        end
    end

    assign issue_ready    = issue_ready_q;
    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_be         = mem_be_q;
    assign mem_wdata      = mem_wdata_q;
    assign write_req      = write_req_q;
    assign write_addr     = write_addr_q;
    assign write_data     = write_data_q;
    assign exc_misaligned = exc_mis_q;
    assign exc_timeout    = exc_to_q;

endmodule

// File: tb/tb_lsu_bus_master.sv
// ---------------------------------------------------------------------------
// tb_lsu_bus_master
//   Directed bench for lsu_bus_master. A transaction-level model (effective
//   address, lane arithmetic, known ack schedule) sets the expected outputs
//   for each cycle; one compare process checks them on every falling edge.
//   Captured bus/writeback values are also pinned against literal values.
// ---------------------------------------------------------------------------
module tb_lsu_bus_master;

    localparam int TO = 16;
    localparam logic [5:0] LB = 6'd11, LH = 6'd12, LW = 6'd13, LBU = 6'd14,
                           LHU = 6'd15, SB = 6'd16, SH = 6'd17, SW = 6'd18;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        issue_valid = 1'b0, flush = 1'b0, mem_ack = 1'b0;
    logic [5:0]  operation_con = '0;
    logic [31:0] src1_value = '0, src2_value = '0, imm = '0, mem_rdata = '0;
    logic [4:0]  rd = '0;
    logic        issue_ready, mem_req, mem_we, write_req, exc_misaligned, exc_timeout;
    logic [29:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata, write_data;
    logic [4:0]  write_addr;

    lsu_bus_master #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset_n(reset_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .flush(flush), .operation_con(operation_con), .src1_value(src1_value),
        .src2_value(src2_value), .imm(imm), .rd(rd), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .write_req(write_req), .write_addr(write_addr),
        .write_data(write_data), .exc_misaligned(exc_misaligned), .exc_timeout(exc_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, required %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outputs for the current cycle.
    logic        e_ready = 1'b1, e_req = 1'b0, e_we = 1'b0, e_wr = 1'b0, e_mis = 1'b0, e_to = 1'b0;
    logic [29:0] e_addr = '0;
    logic [3:0]  e_be = '0;
    logic [31:0] e_wdata = '0, e_wbd = '0;
    logic [4:0]  e_waddr = '0;
    logic        check_en = 1'b0;

    // Observations for literal checks.
    logic [29:0] cap_addr;
    logic [3:0]  cap_be;
    logic [31:0] cap_wdata, cap_wbd;
    logic        cap_we;
    logic [4:0]  cap_waddr;
    int req_cycles = 0, wb_cnt = 0, mis_cnt = 0, to_cnt = 0;

    always @(negedge clk) begin
        if (check_en) begin
            check("issue_ready", 32'(issue_ready), 32'(e_ready));
            check("mem_req", 32'(mem_req), 32'(e_req));
            check("write_req", 32'(write_req), 32'(e_wr));
            check("write_addr", 32'(write_addr), 32'(e_waddr));
            check("write_data", write_data, e_wbd);
            check("exc_misaligned", 32'(exc_misaligned), 32'(e_mis));
            check("exc_timeout", 32'(exc_timeout), 32'(e_to));
            if (e_req) begin
                check("mem_we", 32'(mem_we), 32'(e_we));
                check("mem_addr", 32'(mem_addr), 32'(e_addr));
                check("mem_be", 32'(mem_be), 32'(e_be));
                if (e_we) check("mem_wdata", mem_wdata, e_wdata);
            end
        end
        if (reset_n) begin
            if (mem_req) begin
                cap_addr <= mem_addr; cap_be <= mem_be; cap_wdata <= mem_wdata; cap_we <= mem_we;
                req_cycles <= req_cycles + 1;
            end
            if (write_req) begin
                cap_waddr <= write_addr; cap_wbd <= write_data; wb_cnt <= wb_cnt + 1;
            end
            if (exc_misaligned) mis_cnt <= mis_cnt + 1;
            if (exc_timeout)    to_cnt  <= to_cnt + 1;
        end
    end

    // ---------------- model: plain arithmetic on the operation -------------
    function automatic bit m_store(input logic [5:0] op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction
    function automatic int m_size(input logic [5:0] op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction
    function automatic logic [3:0] m_be(input logic [5:0] op, input logic [31:0] ea);
        if (!m_store(op) || m_size(op) == 4) return 4'hF;
        if (m_size(op) == 1) return 4'(1 << (ea % 4));
        return (ea % 4 >= 2) ? 4'hC : 4'h3;
    endfunction
    function automatic logic [31:0] m_wdata(input logic [5:0] op, input logic [31:0] d);
        if (m_size(op) == 1) return (d & 32'hFF) * 32'h01010101;
        if (m_size(op) == 2) return (d & 32'hFFFF) * 32'h00010001;
        return d;
    endfunction
    function automatic logic [31:0] m_load(input logic [5:0] op, input logic [31:0] ea, input logic [31:0] w);
        logic [31:0] v;
        if (m_size(op) == 1) begin
            v = (w >> (8 * (ea % 4))) & 32'hFF;
            if (op == LB && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (m_size(op) == 2) begin
            v = (w >> (16 * ((ea / 2) % 2))) & 32'hFFFF;
            if (op == LH && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One operation offered in the current IDLE cycle; ack after ack_delay
    // wait cycles (ack_delay >= TO means never).
    task automatic do_txn(input logic [5:0] op, input logic [31:0] s1, input logic [31:0] s2,
                          input logic [31:0] im, input logic [31:0] rdv, input logic [4:0] rdi,
                          input int ack_delay, input logic fl_issue, input logic fl_req);
        logic [31:0] ea;
        bit          done;
        ea = s1 + im;
        issue_valid = 1'b1; operation_con = op; src1_value = s1; src2_value = s2; imm = im;
        rd = rdi; flush = fl_issue;
        tick();
        issue_valid = 1'b0; flush = 1'b0;
        if (op < LB || op > SW || fl_issue) begin
            tick();
            return;
        end
        if ((m_size(op) == 2 && ea % 2 != 0) || (m_size(op) == 4 && ea % 4 != 0)) begin
            e_mis = 1'b1;
            tick();
            e_mis = 1'b0;
            return;
        end
        e_req = 1'b1; e_ready = 1'b0; e_we = m_store(op); e_addr = ea[31:2];
        e_be = m_be(op, ea); e_wdata = m_wdata(op, s2);
        flush = fl_req;
        mem_rdata = 32'h5A5A5A5A;
        done = 1'b0;
        for (int k = 1; k <= TO; k++) begin
            if (!done) begin
                if (k == ack_delay + 1) begin
                    mem_ack = 1'b1; mem_rdata = rdv;
                    tick();
                    mem_ack = 1'b0; mem_rdata = 32'h0;
                    e_req = 1'b0;
                    done = 1'b1;
                    if (!m_store(op)) begin
                        if (rdi != 5'd0) begin
                            e_wr = 1'b1; e_waddr = rdi; e_wbd = m_load(op, ea, rdv);
                        end
                        tick();
                        e_wr = 1'b0;
                    end
                    e_ready = 1'b1;
                end else begin
                    tick();
                end
            end
        end
        if (!done) begin
            e_req = 1'b0; e_to = 1'b1; e_ready = 1'b1;
            tick();
            e_to = 1'b0;
        end
        flush = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_issue_ready"}, 32'(issue_ready), 32'd1);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        check({tag, "_bus"}, {mem_we, 1'b0, mem_addr} | 32'(mem_be) | mem_wdata, 32'd0);
        check({tag, "_wb"}, 32'(write_req) | 32'(write_addr) | write_data, 32'd0);
        check({tag, "_exc"}, 32'(exc_misaligned) | 32'(exc_timeout), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    int r0, w0, m0, t0;

    initial begin
        #23;
        check_reset_outputs("reset");
        tick();
        reset_n = 1'b1;
        check_en = 1'b1;
        tick();

        // SW 0x100+4
        w0 = wb_cnt;
        do_txn(SW, 32'h100, 32'hDEADBEEF, 32'h4, 32'h0, 5'd3, 0, 1'b0, 1'b0);
        check("sw_addr", 32'(cap_addr), 32'h41);
        check("sw_be", 32'(cap_be), 32'hF);
        check("sw_we", 32'(cap_we), 32'd1);
        check("sw_wdata", cap_wdata, 32'hDEADBEEF);
        check("sw_no_wb", wb_cnt, w0);

        // LB / LBU at 0x103
        do_txn(LB, 32'h100, 32'h0, 32'h3, 32'h80123456, 5'd5, 2, 1'b0, 1'b0);
        check("lb_waddr", 32'(cap_waddr), 32'd5);
        check("lb_wdata", cap_wbd, 32'hFFFFFF80);
        do_txn(LBU, 32'h100, 32'h0, 32'h3, 32'h80123456, 5'd5, 0, 1'b0, 1'b0);
        check("lbu_wdata", cap_wbd, 32'h00000080);

        // SH at 0x102, SB at 0x101
        do_txn(SH, 32'h100, 32'h00001234, 32'h2, 32'h0, 5'd0, 1, 1'b0, 1'b0);
        check("sh_be", 32'(cap_be), 32'hC);
        check("sh_wdata", cap_wdata, 32'h12341234);
        do_txn(SB, 32'h100, 32'h000000AB, 32'h1, 32'h0, 5'd0, 0, 1'b0, 1'b0);
        check("sb_be", 32'(cap_be), 32'h2);
        check("sb_wdata", cap_wdata, 32'hABABABAB);

        // LW misaligned at 0x102
        r0 = req_cycles; m0 = mis_cnt;
        do_txn(LW, 32'h100, 32'h0, 32'h2, 32'h0, 5'd4, 0, 1'b0, 1'b0);
        tick();
        check("mis_pulses", mis_cnt, m0 + 1);
        check("mis_no_req", req_cycles, r0);

        // Halfword loads: upper half signed, lower half unsigned
        do_txn(LH, 32'h0FE, 32'h0, 32'h4, 32'h80017FFF, 5'd9, 0, 1'b0, 1'b0);
        check("lh_wdata", cap_wbd, 32'hFFFF8001);
        do_txn(LHU, 32'h100, 32'h0, 32'h0, 32'h1234F00D, 5'd10, 0, 1'b0, 1'b0);
        check("lhu_wdata", cap_wbd, 32'h0000F00D);

        // Timeout, then ack in the last counted cycle
        r0 = req_cycles; t0 = to_cnt; w0 = wb_cnt;
        do_txn(LW, 32'h200, 32'h0, 32'h0, 32'h0, 5'd6, TO, 1'b0, 1'b0);
        tick();
        check("to_pulses", to_cnt, t0 + 1);
        check("to_req_cycles", req_cycles, r0 + TO);
        check("to_no_wb", wb_cnt, w0);
        check("to_ready", 32'(issue_ready), 32'd1);
        do_txn(LW, 32'h200, 32'h0, 32'h0, 32'hCAFEF00D, 5'd6, TO - 1, 1'b0, 1'b0);
        check("ack16_wdata", cap_wbd, 32'hCAFEF00D);
        check("ack16_no_to", to_cnt, t0 + 1);

        // flush at issue, illegal code, stray ack, flush during REQ
        r0 = req_cycles;
        do_txn(LW, 32'h300, 32'h0, 32'h0, 32'h0, 5'd7, 0, 1'b1, 1'b0);
        do_txn(6'd10, 32'h300, 32'h0, 32'h0, 32'h0, 5'd7, 0, 1'b0, 1'b0);
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick(); tick();
        mem_ack = 1'b0;
        check("ignored_no_req", req_cycles, r0);
        do_txn(SW, 32'h400, 32'h01020304, 32'h0, 32'h0, 5'd0, 3, 1'b0, 1'b1);
        check("flush_req_wdata", cap_wdata, 32'h01020304);

        // Load to x0: bus access, no writeback, writeback outputs hold
        w0 = wb_cnt;
        do_txn(LW, 32'h500, 32'h0, 32'h0, 32'h77777777, 5'd0, 0, 1'b0, 1'b0);
        check("x0_no_wb", wb_cnt, w0);
        check("x0_hold_data", write_data, 32'hCAFEF00D);

        // Reset in the middle of REQ
        w0 = wb_cnt; t0 = to_cnt;
        issue_valid = 1'b1; operation_con = LW; src1_value = 32'h300; imm = 32'h0; rd = 5'd7;
        tick();
        issue_valid = 1'b0;
        e_req = 1'b1; e_ready = 1'b0; e_we = 1'b0; e_addr = 30'hC0; e_be = 4'hF;
        tick(); tick();
        check_en = 1'b0;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("midreq");
        e_req = 1'b0; e_ready = 1'b1; e_waddr = '0; e_wbd = '0;
        tick();
        reset_n = 1'b1;
        check_en = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("rst_no_wb", wb_cnt, w0);
        check("rst_no_to", to_cnt, t0);

        // Back-to-back load after reset still works
        do_txn(LBU, 32'h600, 32'h0, 32'h2, 32'h00AB0000, 5'd1, 0, 1'b0, 1'b0);
        check("post_rst_lbu", cap_wbd, 32'h000000AB);

        check_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
